// File: rtl/pipe_pc_gen.sv
// -----------------------------------------------------------------------------
// pipe_pc_gen
// Next-PC generator for the IF stage of the pipelined CPU.
//
// Holds the program counter and chooses the next PC from, in priority order:
// a live exception, a live taken branch, a buffered (pending) late redirect,
// a decode-stage jump/call, a decode-stage return predicted by a small
// circular return-address stack (RAS), and finally the sequential pc + INC.
// Late redirects that arrive while the PC is held are parked in a one-entry
// pending register and applied on the first cycle the hold releases.
//
// Ports:
//   clock            system clock, rising edge
//   reset            synchronous, active-high reset
//   wpcir            1 = hold PC (stall), 0 = advance
//   exc              late-stage exception request
//   br_taken         late-stage taken branch
//   br_target        branch target
//   jmp              decode-stage jump
//   jmp_target       jump / call target
//   call             decode-stage call (jump + push return address)
//   ret              decode-stage return (jump to RAS top)
//   pc               current PC (registered)
//   pc_plus          pc + INC (combinational from pc)
//   redirect_pending a buffered late redirect waits for the stall to end
//   ras_empty        RAS holds no entries
//   ras_full         RAS holds RAS_DEPTH entries
// -----------------------------------------------------------------------------
module pipe_pc_gen #(
    parameter int                WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_PC  = {WIDTH{1'b1}} << 2,
    parameter logic [WIDTH-1:0]  EXC_VEC   = WIDTH'(32'h0000_0008),
    parameter int                INC       = 4,
    parameter int                RAS_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wpcir,
    input  logic             exc,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jmp,
    input  logic [WIDTH-1:0] jmp_target,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic             redirect_pending,
    output logic             ras_empty,
    output logic             ras_full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    // Architectural state
    logic [WIDTH-1:0] pc_r;
    logic             pend_valid_r;
    logic             pend_exc_r;
    logic [WIDTH-1:0] pend_target_r;
    logic [WIDTH-1:0] ras_mem_r [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr_r;
    logic [CNT_W-1:0] ras_cnt_r;

    // Next-state and helper signals
    logic [WIDTH-1:0] pc_plus_s;
    logic [WIDTH-1:0] pc_nxt_s;
    logic             pend_valid_nxt_s;
    logic             pend_exc_nxt_s;
    logic [WIDTH-1:0] pend_target_nxt_s;
    logic [PTR_W-1:0] ras_ptr_nxt_s;
    logic [CNT_W-1:0] ras_cnt_nxt_s;
    logic             ras_push_s;
    logic             late_s;
    logic [WIDTH-1:0] late_target_s;
    logic [PTR_W-1:0] ras_top_idx_s;
    logic [WIDTH-1:0] ras_top_s;
    logic             ras_empty_s;
    logic             pend_accept_s;

    // Sequential increment; wraps modulo 2^WIDTH by construction.
    assign pc_plus_s     = pc_r + WIDTH'(INC);

    // Late redirect source: an exception always outranks a branch.
    assign late_s        = exc | br_taken;
    assign late_target_s = exc ? EXC_VEC : br_target;

    // The pointer addresses the next free slot, so the top sits one below it.
    assign ras_top_idx_s = ras_ptr_r - PTR_W'(1);
    assign ras_top_s     = ras_mem_r[ras_top_idx_s];
    assign ras_empty_s   = (ras_cnt_r == CNT_W'(0));

    // A buffered exception may only be displaced by another exception.
    assign pend_accept_s = late_s & (~pend_valid_r | exc | ~pend_exc_r);

    // Next-PC selection, pending-buffer update and RAS bookkeeping.
    always_comb begin
        pc_nxt_s          = pc_r;
        pend_valid_nxt_s  = pend_valid_r;
        pend_exc_nxt_s    = pend_exc_r;
        pend_target_nxt_s = pend_target_r;
        ras_ptr_nxt_s     = ras_ptr_r;
        ras_cnt_nxt_s     = ras_cnt_r;
        ras_push_s        = 1'b0;

        if (wpcir) begin
            // PC holds; only the late-redirect buffer can change.
            if (pend_accept_s) begin
                pend_valid_nxt_s  = 1'b1;
                pend_exc_nxt_s    = exc;
                pend_target_nxt_s = late_target_s;
            end else begin
                pend_valid_nxt_s  = pend_valid_r;
            end
            // Latching an exception flushes the return stack immediately.
            if (exc) begin
                ras_cnt_nxt_s = CNT_W'(0);
            end else begin
                ras_cnt_nxt_s = ras_cnt_r;
            end
        end else begin
            // On release the pending entry is either consumed or superseded
            // by a live late redirect, so it is always cleared here.
            pend_valid_nxt_s = 1'b0;
            pend_exc_nxt_s   = 1'b0;

            if (exc) begin
                pc_nxt_s      = EXC_VEC;
                ras_cnt_nxt_s = CNT_W'(0);
            end else if (br_taken) begin
                pc_nxt_s = br_target;
            end else if (pend_valid_r) begin
                pc_nxt_s = pend_target_r;
            end else if (jmp | call) begin
                pc_nxt_s = jmp_target;
                if (call) begin
                    // Circular push: when full the oldest slot is reused.
                    ras_push_s    = 1'b1;
                    ras_ptr_nxt_s = ras_ptr_r + PTR_W'(1);
                    if (ras_cnt_r != CNT_FULL) begin
                        ras_cnt_nxt_s = ras_cnt_r + CNT_W'(1);
                    end else begin
                        ras_cnt_nxt_s = ras_cnt_r;
                    end
                end else begin
                    ras_push_s = 1'b0;
                end
            end else if (ret & ~ras_empty_s) begin
                pc_nxt_s      = ras_top_s;
                ras_ptr_nxt_s = ras_top_idx_s;
                ras_cnt_nxt_s = ras_cnt_r - CNT_W'(1);
            end else begin
                pc_nxt_s = pc_plus_s;
            end
        end
    end

    // PC, pending buffer and RAS pointer/count registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_r          <= RESET_PC;
            pend_valid_r  <= 1'b0;
            pend_exc_r    <= 1'b0;
            pend_target_r <= '0;
            ras_ptr_r     <= '0;
            ras_cnt_r     <= '0;
        end else begin
            pc_r          <= pc_nxt_s;
            pend_valid_r  <= pend_valid_nxt_s;
            pend_exc_r    <= pend_exc_nxt_s;
            pend_target_r <= pend_target_nxt_s;
            ras_ptr_r     <= ras_ptr_nxt_s;
            ras_cnt_r     <= ras_cnt_nxt_s;
        end
    end

    // Return-address storage; written with the caller's pc + INC on a push.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem_r[i] <= '0;
            end
        end else if (ras_push_s) begin
            ras_mem_r[ras_ptr_r] <= pc_plus_s;
        end
    end

    assign pc               = pc_r;
    assign pc_plus          = pc_plus_s;
    assign redirect_pending = pend_valid_r;
    assign ras_empty        = ras_empty_s;
    assign ras_full         = (ras_cnt_r == CNT_FULL);

endmodule

// File: tb/tb_pipe_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_pipe_pc_gen
// Self-checking bench for pipe_pc_gen (default parameters: WIDTH 32,
// RESET_PC FFFFFFFC, EXC_VEC 8, INC 4, RAS_DEPTH 4).
// Directed vector table, a few hand-written multi-cycle sequences, then
// random stimulus against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_pipe_pc_gen;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wpcir = 1'b0;
    logic        exc = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        jmp = 1'b0;
    logic [31:0] jmp_target = 32'h0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        redirect_pending;
    logic        ras_empty;
    logic        ras_full;

    int checks = 0;
    int errors = 0;

    pipe_pc_gen dut (
        .clock            (clock),
        .reset            (reset),
        .wpcir            (wpcir),
        .exc              (exc),
        .br_taken         (br_taken),
        .br_target        (br_target),
        .jmp              (jmp),
        .jmp_target       (jmp_target),
        .call             (call),
        .ret              (ret),
        .pc               (pc),
        .pc_plus          (pc_plus),
        .redirect_pending (redirect_pending),
        .ras_empty        (ras_empty),
        .ras_full         (ras_full)
    );

    // 10 ns clock
    always #5 clock = ~clock;

    typedef struct {
        logic        rst, wp, ex, br;
        logic [31:0] brt;
        logic        jm, cl, rt;
        logic [31:0] jt;
        logic [31:0] e_pc;
        logic        e_pend, e_empty, e_full;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic rst, input logic wp, input logic ex,
                                input logic br, input logic [31:0] brt,
                                input logic jm, input logic cl, input logic rt,
                                input logic [31:0] jt, input logic [31:0] e_pc,
                                input logic e_pend, input logic e_empty,
                                input logic e_full);
        vec_t v;
        v.rst = rst; v.wp = wp; v.ex = ex; v.br = br; v.brt = brt;
        v.jm = jm; v.cl = cl; v.rt = rt; v.jt = jt;
        v.e_pc = e_pc; v.e_pend = e_pend; v.e_empty = e_empty; v.e_full = e_full;
        tbl.push_back(v);
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic void chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endfunction

    // Drive one cycle of inputs, clock it, sample 1 ns after the edge.
    task automatic cyc(input logic rst, input logic wp, input logic ex,
                       input logic br, input logic [31:0] brt, input logic jm,
                       input logic cl, input logic rt, input logic [31:0] jt);
        reset = rst; wpcir = wp; exc = ex; br_taken = br; br_target = brt;
        jmp = jm; call = cl; ret = rt; jmp_target = jt;
        @(posedge clock);
        #1;
    endtask

    task automatic st(input string nm, input logic [31:0] e_pc, input logic e_pend,
                      input logic e_empty, input logic e_full);
        chk({nm, " pc"}, pc, e_pc);
        chk({nm, " pc_plus"}, pc_plus, e_pc + 32'd4);
        chk1({nm, " pend"}, redirect_pending, e_pend);
        chk1({nm, " empty"}, ras_empty, e_empty);
        chk1({nm, " full"}, ras_full, e_full);
    endtask

    // Reference model state: PC, pending entry, RAS as a bounded LIFO queue.
    logic [31:0] m_pc;
    bit          m_pv;
    bit          m_pexc;
    logic [31:0] m_pt;
    logic [31:0] m_ras[$];

    task automatic model_step(input logic rst, input logic wp, input logic ex,
                              input logic br, input logic [31:0] brt, input logic jm,
                              input logic cl, input logic rt, input logic [31:0] jt);
        logic [31:0] tgt;
        tgt = ex ? 32'h0000_0008 : brt;
        if (rst) begin
            m_pc = 32'hFFFF_FFFC; m_pv = 0; m_pexc = 0; m_ras.delete();
        end else if (wp) begin
            if ((ex || br) && (!m_pv || ex || !m_pexc)) begin
                m_pv = 1; m_pexc = ex; m_pt = tgt;
            end
            if (ex) m_ras.delete();
        end else begin
            if (ex) begin
                m_pc = 32'h0000_0008; m_ras.delete();
            end else if (br) begin
                m_pc = brt;
            end else if (m_pv) begin
                m_pc = m_pt;
            end else if (jm || cl) begin
                if (cl) begin
                    m_ras.push_back(m_pc + 32'd4);
                    if (m_ras.size() > 4) void'(m_ras.pop_front());
                end
                m_pc = jt;
            end else if (rt && m_ras.size() > 0) begin
                m_pc = m_ras.pop_back();
            end else begin
                m_pc = m_pc + 32'd4;
            end
            m_pv = 0; m_pexc = 0;
        end
    endtask

    initial begin
        // ---------------- directed vector table ----------------
        //   rst wp ex br brt          jm cl rt jt            pc           pd em fu
        add(1, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'hFFFFFFFC, 0, 1, 0);
        add(0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h00000000, 0, 1, 0);
        add(0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h00000004, 0, 1, 0);
        add(0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h00000008, 0, 1, 0);
        add(0, 0, 0, 0, 32'h0,        1, 0, 0, 32'h100,      32'h00000100, 0, 1, 0);
        add(0, 1, 0, 1, 32'h200,      0, 0, 0, 32'h0,        32'h00000100, 1, 1, 0);
        add(0, 1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h00000100, 1, 1, 0);
        add(0, 1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h00000100, 1, 1, 0);
        add(0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h00000200, 0, 1, 0);
        add(0, 1, 0, 1, 32'h300,      0, 0, 0, 32'h0,        32'h00000200, 1, 1, 0);
        add(0, 1, 1, 0, 32'h0,        0, 0, 0, 32'h0,        32'h00000200, 1, 1, 0);
        add(0, 1, 0, 1, 32'h400,      0, 0, 0, 32'h0,        32'h00000200, 1, 1, 0);
        add(0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h00000008, 0, 1, 0);
        add(0, 0, 0, 0, 32'h0,        1, 0, 0, 32'h10,       32'h00000010, 0, 1, 0);
        add(0, 0, 0, 0, 32'h0,        0, 1, 0, 32'h80,       32'h00000080, 0, 0, 0);
        add(0, 0, 0, 0, 32'h0,        0, 1, 0, 32'hC0,       32'h000000C0, 0, 0, 0);
        add(0, 0, 0, 0, 32'h0,        0, 0, 1, 32'h0,        32'h00000084, 0, 0, 0);
        add(0, 0, 0, 0, 32'h0,        0, 0, 1, 32'h0,        32'h00000014, 0, 1, 0);
        add(0, 0, 0, 0, 32'h0,        0, 0, 1, 32'h0,        32'h00000018, 0, 1, 0);
        add(0, 1, 0, 0, 32'h0,        0, 1, 0, 32'h999,      32'h00000018, 0, 1, 0);
        add(0, 0, 1, 1, 32'h700,      0, 0, 0, 32'h0,        32'h00000008, 0, 1, 0);
        add(0, 0, 0, 0, 32'h0,        0, 1, 1, 32'h40,       32'h00000040, 0, 0, 0);
        add(0, 1, 0, 1, 32'h500,      0, 0, 0, 32'h0,        32'h00000040, 1, 0, 0);
        add(0, 0, 0, 1, 32'h600,      0, 0, 0, 32'h0,        32'h00000600, 0, 0, 0);
        add(0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h00000604, 0, 0, 0);
        add(0, 0, 0, 0, 32'h0,        0, 0, 1, 32'h0,        32'h0000000C, 0, 1, 0);
        add(0, 0, 0, 0, 32'h0,        0, 1, 0, 32'h100,      32'h00000100, 0, 0, 0);
        add(0, 0, 1, 0, 32'h0,        0, 0, 0, 32'h0,        32'h00000008, 0, 1, 0);
        add(0, 0, 0, 0, 32'h0,        0, 0, 1, 32'h0,        32'h0000000C, 0, 1, 0);
        add(0, 0, 0, 0, 32'h0,        0, 1, 0, 32'h200,      32'h00000200, 0, 0, 0);
        add(0, 1, 1, 0, 32'h0,        0, 0, 0, 32'h0,        32'h00000200, 1, 1, 0);
        add(0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h00000008, 0, 1, 0);

        foreach (tbl[i]) begin
            cyc(tbl[i].rst, tbl[i].wp, tbl[i].ex, tbl[i].br, tbl[i].brt,
                tbl[i].jm, tbl[i].cl, tbl[i].rt, tbl[i].jt);
            st($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_pend,
               tbl[i].e_empty, tbl[i].e_full);
        end

        // ---------------- RAS overflow: five calls, depth four ----------------
        cyc(0, 0, 0, 0, 32'h0, 1, 0, 0, 32'h1000);
        st("ovf jmp", 32'h1000, 0, 1, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 0, 0, 32'h0, 0, 1, 0, 32'((k + 2) * 32'h1000));
            st($sformatf("ovf call%0d", k), 32'((k + 2) * 32'h1000), 0, 0, (k >= 3));
        end
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 0, 32'h0, 0, 0, 1, 32'h0);
            st($sformatf("ovf ret%0d", k), 32'((5 - k) * 32'h1000 + 32'h4), 0, (k == 3), 0);
        end
        cyc(0, 0, 0, 0, 32'h0, 0, 0, 1, 32'h0);
        st("ovf ret empty", 32'h2008, 0, 1, 0);

        // ---------------- reset with pending redirect and RAS count 2 ----------
        cyc(0, 0, 0, 0, 32'h0, 1, 0, 0, 32'h1000);
        cyc(0, 0, 0, 0, 32'h0, 0, 1, 0, 32'h2000);
        cyc(0, 0, 0, 0, 32'h0, 0, 1, 0, 32'h3000);
        cyc(0, 1, 0, 1, 32'h700, 0, 0, 0, 32'h0);
        st("pre-reset", 32'h3000, 1, 0, 0);
        cyc(1, 1, 1, 1, 32'h900, 0, 1, 0, 32'h800);
        st("reset override", 32'hFFFFFFFC, 0, 1, 0);
        chk("wrap pc_plus", pc_plus, 32'h0);
        cyc(0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
        st("wrap", 32'h0, 0, 1, 0);

        // ---------------- random stimulus vs reference model ----------------
        cyc(1, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
        model_step(1, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
        for (int n = 0; n < 3000; n++) begin
            logic r_rst, r_wp, r_ex, r_br, r_jm, r_cl, r_rt;
            logic [31:0] r_brt, r_jt;
            r_rst = ($urandom_range(99) < 2);
            r_wp  = ($urandom_range(99) < 30);
            r_ex  = ($urandom_range(99) < 5);
            r_br  = ($urandom_range(99) < 15);
            r_jm  = ($urandom_range(99) < 10);
            r_cl  = ($urandom_range(99) < 20);
            r_rt  = ($urandom_range(99) < 20);
            r_brt = $urandom() & 32'hFFFF_FFFC;
            r_jt  = $urandom() & 32'hFFFF_FFFC;
            cyc(r_rst, r_wp, r_ex, r_br, r_brt, r_jm, r_cl, r_rt, r_jt);
            model_step(r_rst, r_wp, r_ex, r_br, r_brt, r_jm, r_cl, r_rt, r_jt);
            st($sformatf("rnd%0d", n), m_pc, m_pv, (m_ras.size() == 0), (m_ras.size() == 4));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
